// File: rtl/ring4bd_ctrl.sv
// rtl/ring4bd_ctrl.sv - command sequencer for a 4-bit bidirectional ring counter
//
// Owns the ring counter's load/data/mod inputs. A command (pattern, direction,
// step count) is loaded into the ring, the ring is let run for exactly the
// requested number of rotations (or fewer on abort), then frozen and its final
// value is reported.
//
// Optional build macro: RING4BD_CTRL_CHECK_EN enables a shadow prediction of
// the ring value and a sticky err flag on any disagreement.
//
// Ports:
//   clock, reset            clock; asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_pattern/dir/steps   preload value, 0=left 1=right, rotation count
//   abort                   end the current run early (honoured only in RUN)
//   ring_count              ring counter output
//   ring_load/data/mod      ring counter controls
//   busy, done, aborted     run status; done is a one-cycle pulse
//   result                  ring value captured when leaving DONE
//   steps_left              remaining rotations
//   err                     sticky rotation-check error
module ring4bd_ctrl #(
  parameter int STEP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_pattern,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  input  logic [3:0]        ring_count,
  output logic              ring_load,
  output logic [3:0]        ring_data,
  output logic              ring_mod,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [3:0]        result,
  output logic [STEP_W-1:0] steps_left,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] pat_q;

  // ring_mod doubles as the stored direction of the accepted command.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      result     <= 4'd0;
      steps_left <= '0;
      ring_mod   <= 1'b0;
      pat_q      <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pat_q      <= cmd_pattern;
            ring_mod   <= cmd_dir;
            steps_left <= cmd_steps;
            aborted    <= 1'b0;
            busy       <= 1'b1;
            cmd_ready  <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (steps_left != '0) begin
            state <= RUN;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          // The ring rotates on this edge regardless, so the count follows it.
          if (steps_left != '0) steps_left <= steps_left - STEP_ONE;
          if (abort || steps_left <= STEP_ONE) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            aborted <= abort;
          end
        end
        DONE: begin
          // Ring is frozen in DONE, so ring_count is the final value here.
          result    <= ring_count;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outside RUN the ring is held by reloading either its own value or the
  // preload pattern.
  always_comb begin
    ring_load = 1'b1;
    ring_data = ring_count;
    case (state)
      LOAD: ring_data = pat_q;
      RUN: begin
        ring_load = 1'b0;
        ring_data = pat_q;
      end
      default: ;
    endcase
  end

`ifdef RING4BD_CTRL_CHECK_EN
  logic [3:0] pred;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred <= 4'd0;
      err  <= 1'b0;
    end else begin
      if (state == LOAD)
        pred <= pat_q;
      else if (state == RUN)
        pred <= ring_mod ? {pred[0], pred[3:1]} : {pred[2:0], pred[3]};
      if ((state == RUN || state == DONE) && ring_count != pred)
        err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ring4bd_ctrl.sv
// tb/tb_ring4bd_ctrl.sv - randomized scoreboard bench for ring4bd_ctrl
module tb_ring4bd_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_pattern = 4'd0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_steps = 8'd0;
  logic       abort = 1'b0;
  logic [3:0] ring_count;
  logic       ring_load;
  logic [3:0] ring_data;
  logic       ring_mod;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] result;
  logic [7:0] steps_left;
  logic       err;

  ring4bd_ctrl #(.STEP_W(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .abort(abort), .ring_count(ring_count),
    .ring_load(ring_load), .ring_data(ring_data), .ring_mod(ring_mod),
    .busy(busy), .done(done), .aborted(aborted), .result(result),
    .steps_left(steps_left), .err(err)
  );

  always #5 clock = ~clock;

  // Ring counter environment model; glitch corrupts only what the DUT sees.
  logic [3:0] ring_q = 4'b0101;
  logic [3:0] glitch = 4'd0;
  assign ring_count = ring_q ^ glitch;
  always @(posedge clock)
    ring_q <= ring_load ? ring_data : (ring_mod ? {ring_q[0], ring_q[3:1]} : {ring_q[2:0], ring_q[3]});

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] res;
    logic       ab;
    logic [7:0] sl;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int run_lo = 1, run_hi = 0, abort_cyc = -1, last_acc = 0;
  bit noise_en = 1'b1;
  bit pend = 1'b0;
  exp_t cur;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rotating right by n equals rotating left by 4-(n mod 4).
  function automatic logic [3:0] rot_ref(input logic [3:0] p, input logic d, input int n);
    int k;
    logic [7:0] w;
    k = n % 4;
    if (d) k = (4 - k) % 4;
    w = {p, p} << k;
    return w[7:4];
  endfunction

  task automatic offer(input logic [3:0] p, input logic d, input logic [7:0] s,
                       input int j, input int gap);
    int waited;
    int rot;
    exp_t e;
    waited = 0;
    cmd_valid = 1'b0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    while (!cmd_ready && waited < 400) begin
      cmd_valid   = 1'($urandom);
      cmd_pattern = 4'($urandom);
      cmd_dir     = 1'($urandom);
      cmd_steps   = 8'($urandom);
      waited++;
      @(negedge clock);
    end
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    cmd_valid = 1'b1; cmd_pattern = p; cmd_dir = d; cmd_steps = s;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    rot = (j > 0 && j <= int'(s)) ? j : int'(s);
    e.ab  = (j > 0 && j <= int'(s));
    e.res = rot_ref(p, d, rot);
    e.sl  = 8'(int'(s) - rot);
    e.acc = cyc;
    e.lat = 1 + rot;
    last_acc  = cyc;
    run_lo    = cyc + 1;
    run_hi    = cyc + rot;
    abort_cyc = e.ab ? cyc + j : -1;
    sb.push_back(e);
  endtask

  // abort driver: planned pulse inside the run window, random noise elsewhere.
  initial begin
    forever begin
      @(negedge clock);
      if (cyc >= run_lo && cyc <= run_hi) abort = (cyc == abort_cyc);
      else abort = noise_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("result", int'(result), int'(cur.res));
          check("ring_frozen", int'(ring_count), int'(cur.res));
          pend = 1'b0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            cur = sb.pop_front();
            check("done_latency", cyc - cur.acc, cur.lat);
            check("aborted", int'(aborted), int'(cur.ab));
            check("steps_left", int'(steps_left), int'(cur.sl));
            check("busy_in_done", int'(busy), 0);
            check("ready_in_done", int'(cmd_ready), 0);
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int w;
    int s;
    int j;
    logic [3:0] rv;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_err", int'(err), 0);
    check("rst_steps_left", int'(steps_left), 0);
    check("rst_ring_load", int'(ring_load), 1);
    check("rst_ring_mod", int'(ring_mod), 0);

    offer(4'b0001, 1'b0, 8'd3, 0, 1);
    offer(4'b1001, 1'b1, 8'd0, 0, 1);
    offer(4'b0001, 1'b1, 8'd10, 2, 1);
    offer(4'b0110, 1'b0, 8'd2, 0, 1);
    offer(4'b1100, 1'b1, 8'd1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 12));
      j = (s > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, s)) : 0;
      offer(4'($urandom), 1'($urandom), 8'(s), j, int'($urandom_range(0, 2)));
    end

    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clock);
      w++;
    end
    check("drain", sb.size(), 0);

`ifdef RING4BD_CTRL_CHECK_EN
    offer(4'b0011, 1'b0, 8'd4, 0, 0);
    @(negedge clock);
    @(negedge clock);
    glitch = 4'b1000;
    @(negedge clock);
    glitch = 4'd0;
    repeat (6) @(negedge clock);
    check("err_set", int'(err), 1);
    offer(4'b0101, 1'b1, 8'd2, 0, 0);
    repeat (6) @(negedge clock);
    check("err_sticky", int'(err), 1);
`else
    check("err_tied", int'(err), 0);
`endif

    // Reset in the middle of a run: ring freezes, no done pulse.
    noise_en = 1'b0;
    offer(4'b0001, 1'b0, 8'd30, 0, 0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    sb.delete();
    run_lo = 1; run_hi = 0; abort_cyc = -1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(cmd_ready), 1);
    check("mid_rst_steps_left", int'(steps_left), 0);
    check("mid_rst_ring_load", int'(ring_load), 1);
    rv = ring_count;
    repeat (3) @(negedge clock);
    check("mid_rst_ring_hold", int'(ring_count), int'(rv));
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_ring_hold", int'(ring_count), int'(rv));
    check("post_rst_err", int'(err), 0);
    check("post_rst_result", int'(result), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
